// File: rtl/axil_access_arbiter.sv
// axil_access_arbiter: shares one AXI-Lite manager port between two
// register-access requesters, one transaction in flight, round-robin grant.
module axil_access_arbiter #(
  parameter int         DATA_WIDTH    = 32,
  parameter int         ADDRESS_WIDTH = 4,
  parameter logic [2:0] PROT          = 3'b000
) (
  input  logic                          axi_aclk_in,
  input  logic                          axi_areset_in,
  input  logic [1:0]                    req_valid_in,
  input  logic [1:0]                    req_write_in,
  input  logic [2*ADDRESS_WIDTH-1:0]    req_addr_in,
  input  logic [2*DATA_WIDTH-1:0]       req_wdata_in,
  input  logic [2*(DATA_WIDTH/8)-1:0]   req_wstrb_in,
  output logic [1:0]                    req_grant_out,
  output logic [1:0]                    req_done_out,
  output logic [DATA_WIDTH-1:0]         rsp_rdata_out,
  output logic [1:0]                    rsp_resp_out,
  output logic [ADDRESS_WIDTH-1:0]      m_axi_awaddr_out,
  output logic                          m_axi_awvalid_out,
  input  logic                          m_axi_awready_in,
  output logic [DATA_WIDTH-1:0]         m_axi_wdata_out,
  output logic [DATA_WIDTH/8-1:0]       m_axi_wstrb_out,
  output logic                          m_axi_wvalid_out,
  input  logic                          m_axi_wready_in,
  input  logic [1:0]                    m_axi_bresp_in,
  input  logic                          m_axi_bvalid_in,
  output logic                          m_axi_bready_out,
  output logic [ADDRESS_WIDTH-1:0]      m_axi_araddr_out,
  output logic                          m_axi_arvalid_out,
  input  logic                          m_axi_arready_in,
  input  logic [DATA_WIDTH-1:0]         m_axi_rdata_in,
  input  logic [1:0]                    m_axi_rresp_in,
  input  logic                          m_axi_rvalid_in,
  output logic                          m_axi_rready_out,
  output logic [2:0]                    m_axi_awprot_out,
  output logic [2:0]                    m_axi_arprot_out
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_RESP, DONE
  } state_t;

  state_t          state_q, state_d;
  logic            id_q, id_d;
  logic            fav_q, fav_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic [SW-1:0]   strb_q, strb_d;
  logic            awv_q, awv_d;
  logic            wv_q, wv_d;
  logic            arv_q, arv_d;
  logic            br_q, br_d;
  logic            rr_q, rr_d;
  logic [1:0]      grant_q, grant_d;
  logic [1:0]      done_q, done_d;
  logic [1:0]      resp_q, resp_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            win;

  // fav_q names the requester that wins a tie
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    fav_d   = fav_q;
    addr_d  = addr_q;
    data_d  = data_q;
    strb_d  = strb_q;
    awv_d   = awv_q;
    wv_d    = wv_q;
    arv_d   = arv_q;
    br_d    = br_q;
    rr_d    = rr_q;
    grant_d = '0;
    done_d  = '0;
    resp_d  = resp_q;
    rdata_d = rdata_q;
    win     = (&req_valid_in) ? fav_q
                              : ~req_valid_in[0];
    unique case (state_q)
      IDLE: begin
        if (|req_valid_in) begin
          id_d = win;
          grant_d[win] = 1'b1;
          addr_d = win ? req_addr_in[2*AW-1:AW]
                       : req_addr_in[AW-1:0];
          data_d = win ? req_wdata_in[2*DW-1:DW]
                       : req_wdata_in[DW-1:0];
          strb_d = win ? req_wstrb_in[2*SW-1:SW]
                       : req_wstrb_in[SW-1:0];
          if (req_write_in[win]) begin
            state_d = WR_ADDR;
            awv_d   = 1'b1;
            wv_d    = 1'b1;
          end else begin
            state_d = RD_ADDR;
            arv_d   = 1'b1;
          end
        end
      end
      WR_ADDR: begin
        if (m_axi_awready_in) awv_d = 1'b0;
        if (m_axi_wready_in)  wv_d  = 1'b0;
        if (!awv_d && !wv_d) begin
          state_d = WR_RESP;
          br_d    = 1'b1;
        end
      end
      WR_RESP: begin
        if (m_axi_bvalid_in) begin
          resp_d       = m_axi_bresp_in;
          br_d         = 1'b0;
          done_d[id_q] = 1'b1;
          state_d      = DONE;
        end
      end
      RD_ADDR: begin
        if (m_axi_arready_in) begin
          arv_d   = 1'b0;
          rr_d    = 1'b1;
          state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        if (m_axi_rvalid_in) begin
          rdata_d      = m_axi_rdata_in;
          resp_d       = m_axi_rresp_in;
          rr_d         = 1'b0;
          done_d[id_q] = 1'b1;
          state_d      = DONE;
        end
      end
      DONE: begin
        fav_d   = ~id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk_in or posedge axi_areset_in) begin
    if (axi_areset_in) begin
      state_q <= IDLE;
      id_q    <= 1'b0;
      fav_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      awv_q   <= 1'b0;
      wv_q    <= 1'b0;
      arv_q   <= 1'b0;
      br_q    <= 1'b0;
      rr_q    <= 1'b0;
      grant_q <= '0;
      done_q  <= '0;
      resp_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      fav_q   <= fav_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      awv_q   <= awv_d;
      wv_q    <= wv_d;
      arv_q   <= arv_d;
      br_q    <= br_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_grant_out     = grant_q;
  assign req_done_out      = done_q;
  assign rsp_rdata_out     = rdata_q;
  assign rsp_resp_out      = resp_q;
  assign m_axi_awaddr_out  = addr_q;
  assign m_axi_awvalid_out = awv_q;
  assign m_axi_wdata_out   = data_q;
  assign m_axi_wstrb_out   = strb_q;
  assign m_axi_wvalid_out  = wv_q;
  assign m_axi_bready_out  = br_q;
  assign m_axi_araddr_out  = addr_q;
  assign m_axi_arvalid_out = arv_q;
  assign m_axi_rready_out  = rr_q;
  assign m_axi_awprot_out  = PROT;
  assign m_axi_arprot_out  = PROT;

endmodule

// File: tb/tb_axil_access_arbiter.sv
// tb_axil_access_arbiter: directed requester traffic against a 4-register
// AXI-Lite subordinate, checked every cycle by a transaction-level model.
`timescale 1ns/1ps
module tb_axil_access_arbiter;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]      req_valid, req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [2*SW-1:0] req_wstrb;
  logic [1:0]      grant, done, rsp_resp;
  logic [DW-1:0]   rsp_rdata;
  logic [AW-1:0]   awaddr, araddr;
  logic            awvalid, awready, wvalid, wready;
  logic [DW-1:0]   wdata, rdata;
  logic [SW-1:0]   wstrb;
  logic [1:0]      bresp, rresp;
  logic            bvalid, bready, arvalid, arready;
  logic            rvalid, rready;
  logic [2:0]      awprot, arprot;

  axil_access_arbiter dut (
    .axi_aclk_in       (clk),
    .axi_areset_in     (rst),
    .req_valid_in      (req_valid),
    .req_write_in      (req_write),
    .req_addr_in       (req_addr),
    .req_wdata_in      (req_wdata),
    .req_wstrb_in      (req_wstrb),
    .req_grant_out     (grant),
    .req_done_out      (done),
    .rsp_rdata_out     (rsp_rdata),
    .rsp_resp_out      (rsp_resp),
    .m_axi_awaddr_out  (awaddr),
    .m_axi_awvalid_out (awvalid),
    .m_axi_awready_in  (awready),
    .m_axi_wdata_out   (wdata),
    .m_axi_wstrb_out   (wstrb),
    .m_axi_wvalid_out  (wvalid),
    .m_axi_wready_in   (wready),
    .m_axi_bresp_in    (bresp),
    .m_axi_bvalid_in   (bvalid),
    .m_axi_bready_out  (bready),
    .m_axi_araddr_out  (araddr),
    .m_axi_arvalid_out (arvalid),
    .m_axi_arready_in  (arready),
    .m_axi_rdata_in    (rdata),
    .m_axi_rresp_in    (rresp),
    .m_axi_rvalid_in   (rvalid),
    .m_axi_rready_out  (rready),
    .m_axi_awprot_out  (awprot),
    .m_axi_arprot_out  (arprot)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                          input logic [DW-1:0] nw,
                                          input logic [SW-1:0] s);
    merge = old;
    for (int k = 0; k < SW; k++)
      if (s[k]) merge[8*k +: 8] = nw[8*k +: 8];
  endfunction

  // ---------------- subordinate: 4 registers, programmable stalls
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0] sub_resp = 2'b00;
  int aw_wait, w_wait, ar_wait, b_wait, r_wait;
  logic got_aw, got_w, b_pend, r_pend;
  logic [AW-1:0] aw_lat;
  logic [DW-1:0] w_lat, r_lat;
  logic [SW-1:0] s_lat;
  logic [DW-1:0] sregs [4];
  logic aw_hs, w_hs, ar_hs, have_aw, have_w;
  logic [AW-1:0] a_eff;
  logic [DW-1:0] d_eff;
  logic [SW-1:0] s_eff;

  assign awready = awvalid && (aw_wait >= aw_dly);
  assign wready  = wvalid && (w_wait >= w_dly);
  assign arready = arvalid && (ar_wait >= ar_dly);
  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;
  assign ar_hs   = arvalid & arready;
  assign have_aw = got_aw | aw_hs;
  assign have_w  = got_w | w_hs;
  assign a_eff   = aw_hs ? awaddr : aw_lat;
  assign d_eff   = w_hs ? wdata : w_lat;
  assign s_eff   = w_hs ? wstrb : s_lat;
  assign bvalid  = b_pend && (b_wait >= b_dly);
  assign rvalid  = r_pend && (r_wait >= r_dly);
  assign bresp   = sub_resp;
  assign rresp   = sub_resp;
  assign rdata   = r_lat;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
      b_wait <= 0; r_wait <= 0;
      got_aw <= 1'b0; got_w <= 1'b0;
      b_pend <= 1'b0; r_pend <= 1'b0;
      aw_lat <= '0; w_lat <= '0; s_lat <= '0; r_lat <= '0;
      for (int k = 0; k < 4; k++) sregs[k] <= '0;
    end else begin
      aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
      w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
      ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
      if (b_pend && !bvalid) b_wait <= b_wait + 1;
      if (have_aw && have_w && !b_pend) begin
        sregs[a_eff[3:2]] <= merge(sregs[a_eff[3:2]], d_eff, s_eff);
        b_pend <= 1'b1;
        b_wait <= 0;
        got_aw <= 1'b0;
        got_w  <= 1'b0;
      end else begin
        if (aw_hs) begin got_aw <= 1'b1; aw_lat <= awaddr; end
        if (w_hs) begin got_w <= 1'b1; w_lat <= wdata; s_lat <= wstrb; end
      end
      if (bvalid && bready) b_pend <= 1'b0;
      if (ar_hs) begin
        r_pend <= 1'b1;
        r_wait <= 0;
        r_lat  <= sregs[araddr[3:2]];
      end else if (r_pend && !rvalid) begin
        r_wait <= r_wait + 1;
      end
      if (rvalid && rready) r_pend <= 1'b0;
    end
  end

  // ---------------- requester drivers
  typedef struct packed {
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic [7:0]    life;
  } op_t;

  op_t q0[$];
  op_t q1[$];
  int  age [2];
  int  cur_life [2];

  task automatic push(input int i, input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [SW-1:0] s,
                      input int life);
    op_t o;
    o.wr = wr; o.a = a; o.d = d; o.s = s; o.life = 8'(life);
    if (i == 0) q0.push_back(o);
    else q1.push_back(o);
  endtask

  // life 0 holds the request until granted; life n drops it after n cycles
  task automatic step(input int i);
    op_t h;
    bit empty;
    if (req_valid[i] &&
        (grant[i] || (cur_life[i] != 0 && age[i] >= cur_life[i]))) begin
      if (i == 0) void'(q0.pop_front());
      else void'(q1.pop_front());
      age[i] = 0;
    end
    empty = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
    if (empty) begin
      req_valid[i] = 1'b0;
    end else begin
      h = (i == 0) ? q0[0] : q1[0];
      req_valid[i] = 1'b1;
      req_write[i] = h.wr;
      req_addr[i*AW +: AW] = h.a;
      req_wdata[i*DW +: DW] = h.d;
      req_wstrb[i*SW +: SW] = h.s;
      cur_life[i] = int'(h.life);
      age[i]++;
    end
  endtask

  initial begin
    req_valid = '0; req_write = '0; req_addr = '0;
    req_wdata = '0; req_wstrb = '0;
    age[0] = 0; age[1] = 0; cur_life[0] = 0; cur_life[1] = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        q0.delete(); q1.delete();
        req_valid = '0;
        age[0] = 0; age[1] = 0;
      end else begin
        step(0);
        step(1);
      end
    end
  end

  // ---------------- transaction-level model and per-cycle compare
  bit            m_busy, m_id, m_wr, favour, elig, hs_prev;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, m_rexp, exp_rdata;
  logic [SW-1:0] m_strb;
  logic [1:0]    exp_resp;
  logic [DW-1:0] mreg [4];
  logic [1:0]    pv, pw;
  logic [2*AW-1:0] pa;
  logic [2*DW-1:0] pd;
  logic [2*SW-1:0] ps;
  logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [AW-1:0] p_awaddr, p_araddr;
  logic [DW-1:0] p_wdata;
  logic [SW-1:0] p_wstrb;
  int hold_seen = 0;
  int grant_log[$];
  int done_log[$];
  logic [DW-1:0] rdata_log[$];
  logic [1:0] resp_log[$];

  initial begin
    logic [1:0] e_grant, e_done;
    int wi;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("reset_ctrl",
            {grant, done, awvalid, wvalid, arvalid, bready, rready,
             awaddr, araddr, wstrb, rsp_resp}, '0);
        chk("reset_data", {wdata, rsp_rdata}, '0);
        m_busy = 0; favour = 0; elig = 0; hs_prev = 0;
        exp_rdata = '0; exp_resp = '0;
        for (int k = 0; k < 4; k++) mreg[k] = '0;
        pv = '0; p_awv = 0; p_wv = 0; p_arv = 0;
        continue;
      end
      e_done = '0;
      if (hs_prev && m_busy) e_done[m_id] = 1'b1;
      chk("done", done, e_done);
      if (e_done != 0) begin
        if (!m_wr) exp_rdata = m_rexp;
        exp_resp = sub_resp;
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_resp", rsp_resp, exp_resp);
        done_log.push_back(int'(m_id));
        rdata_log.push_back(exp_rdata);
        resp_log.push_back(exp_resp);
        favour = ~m_id;
        m_busy = 0;
      end
      e_grant = '0;
      wi = 0;
      if (elig && pv != 0) begin
        wi = (pv == 2'b11) ? int'(favour) : (pv[0] ? 0 : 1);
        e_grant[wi] = 1'b1;
      end
      chk("grant", grant, e_grant);
      if (e_grant != 0) begin
        m_busy = 1; m_id = wi[0]; m_wr = pw[wi];
        m_addr = pa[wi*AW +: AW];
        m_data = pd[wi*DW +: DW];
        m_strb = ps[wi*SW +: SW];
        if (m_wr) mreg[m_addr[3:2]] = merge(mreg[m_addr[3:2]], m_data, m_strb);
        else m_rexp = mreg[m_addr[3:2]];
        grant_log.push_back(wi);
      end
      if (p_awv && !p_awr) begin
        hold_seen++;
        chk("awvalid_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
      end
      if (p_wv && !p_wr)
        chk("wvalid_hold", {wvalid, wdata, wstrb}, {1'b1, p_wdata, p_wstrb});
      if (p_arv && !p_arr)
        chk("arvalid_hold", {arvalid, araddr}, {1'b1, p_araddr});
      if (awvalid)
        chk("aw_match", {m_busy, m_wr, awaddr}, {2'b11, m_addr});
      if (wvalid)
        chk("w_match", {m_busy, m_wr, wdata, wstrb}, {2'b11, m_data, m_strb});
      if (arvalid)
        chk("ar_match", {m_busy, m_wr, araddr}, {2'b10, m_addr});
      if (bready || rready)
        chk("resp_ready_busy", {m_busy, bready & ~m_wr}, 2'b10);
      chk("prot", {awprot, arprot}, '0);
      hs_prev = (bvalid && bready) || (rvalid && rready);
      elig = !m_busy && (e_done == 0);
      pv = req_valid; pw = req_write; pa = req_addr;
      pd = req_wdata; ps = req_wstrb;
      p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
      p_wv = wvalid; p_wr = wready; p_wdata = wdata; p_wstrb = wstrb;
      p_arv = arvalid; p_arr = arready; p_araddr = araddr;
    end
  end

  // ---------------- directed sequence
  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || m_busy || req_valid != 0)
           && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    repeat (3) @(negedge clk);
    #1;
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL timeout_%s waited=%0d limit=%0d", nm, n, budget);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int gb, db, n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // write then read from the other requester, both valid together
    gb = grant_log.size(); db = done_log.size();
    push(0, 1, 4'h4, 32'hDEADBEEF, 4'hF, 0);
    push(1, 0, 4'h4, 32'h0, 4'h0, 0);
    wait_idle(200, "t1");
    chk("t1_count", {grant_log.size() - gb, done_log.size() - db}, {32'd2, 32'd2});
    chk("t1_grant", {grant_log[gb], grant_log[gb+1]}, {32'd0, 32'd1});
    chk("t1_done", {done_log[db], done_log[db+1]}, {32'd0, 32'd1});
    chk("t1_resp", {resp_log[db], resp_log[db+1]}, 4'b0000);
    chk("t1_rdata", rdata_log[db+1], 32'hDEADBEEF);

    // partial-strobe write
    db = done_log.size();
    push(0, 1, 4'h8, 32'h11223344, 4'hF, 0);
    push(0, 1, 4'h8, 32'hAABBCCDD, 4'b0010, 0);
    push(0, 0, 4'h8, 32'h0, 4'h0, 0);
    wait_idle(300, "t2");
    chk("t2_rdata", {done_log.size() - db, rdata_log[db+2]},
        {32'd3, 32'h1122CC44});

    // both requesters saturated from reset
    do_reset();
    gb = grant_log.size(); db = done_log.size();
    push(0, 1, 4'hC, 32'h0A0A0A0A, 4'hF, 0);
    push(0, 0, 4'hC, 32'h0, 4'h0, 0);
    push(0, 1, 4'h0, 32'h00000005, 4'hF, 0);
    push(1, 0, 4'h8, 32'h0, 4'h0, 0);
    push(1, 1, 4'h4, 32'h00000077, 4'hF, 0);
    push(1, 0, 4'h0, 32'h0, 4'h0, 0);
    wait_idle(600, "t3");
    chk("t3_count", grant_log.size() - gb, 6);
    for (int k = 0; k < 6; k++)
      chk($sformatf("t3_grant%0d", k), grant_log[gb+k], k % 2);
    chk("t3_rd8", rdata_log[db+1], 32'h0);
    chk("t3_rdC", rdata_log[db+2], 32'h0A0A0A0A);
    chk("t3_rd0", rdata_log[db+5], 32'h00000005);

    // stalled subordinate
    aw_dly = 1; w_dly = 3; ar_dly = 2; b_dly = 5; r_dly = 5;
    gb = grant_log.size(); db = done_log.size();
    push(0, 1, 4'h0, 32'hCAFEF00D, 4'hF, 0);
    push(0, 0, 4'h0, 32'h0, 4'h0, 0);
    push(1, 0, 4'h0, 32'h0, 4'h0, 0);
    wait_idle(600, "t4");
    chk("t4_grant_done", {grant_log.size() - gb, done_log.size() - db},
        {32'd3, 32'd3});
    chk("t4_order", {grant_log[gb], grant_log[gb+1], grant_log[gb+2]},
        {32'd0, 32'd1, 32'd0});
    chk("t4_rdata", {rdata_log[db+1], rdata_log[db+2]},
        {32'hCAFEF00D, 32'hCAFEF00D});
    chk("t4_hold_seen", hold_seen > 0, 1);

    // error responses pass through; a write leaves read data alone
    aw_dly = 0; w_dly = 0; ar_dly = 0; b_dly = 0; r_dly = 0;
    db = done_log.size();
    sub_resp = 2'b10;
    push(0, 1, 4'h4, 32'h12345678, 4'hF, 0);
    wait_idle(200, "t5a");
    sub_resp = 2'b11;
    push(1, 0, 4'h4, 32'h0, 4'h0, 0);
    wait_idle(200, "t5b");
    sub_resp = 2'b00;
    chk("t5_slverr", {resp_log[db], rdata_log[db]}, {2'b10, 32'hCAFEF00D});
    chk("t5_decerr", {resp_log[db+1], rdata_log[db+1]}, {2'b11, 32'h12345678});

    // one-cycle request from req1 while req0 busy is never served
    r_dly = 5;
    gb = grant_log.size(); db = done_log.size();
    push(0, 0, 4'h4, 32'h0, 4'h0, 0);
    n = 0;
    while (!grant[0] && n < 50) begin @(negedge clk); n++; end
    chk("t6_grant0_seen", grant[0], 1'b1);
    push(1, 1, 4'h8, 32'hFFFFFFFF, 4'hF, 1);
    wait_idle(200, "t6");
    chk("t6_count", {grant_log.size() - gb, done_log.size() - db},
        {32'd1, 32'd1});
    r_dly = 0;

    // reset while waiting for the write response
    b_dly = 8;
    push(0, 1, 4'h0, 32'h00000001, 4'hF, 0);
    wait_idle(200, "t7a");
    push(0, 1, 4'hC, 32'h00000002, 4'hF, 0);
    n = 0;
    while (!bready && n < 100) begin @(negedge clk); #1; n++; end
    chk("t7_in_wr_resp", bready, 1'b1);
    db = done_log.size();
    #1 rst = 1'b1;
    #1;
    chk("t7_async_clear",
        {awvalid, wvalid, arvalid, bready, rready, grant, done}, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    b_dly = 0;
    gb = grant_log.size();
    push(1, 0, 4'h0, 32'h0, 4'h0, 0);
    push(0, 0, 4'h4, 32'h0, 4'h0, 0);
    wait_idle(300, "t7b");
    chk("t7_first_grant", grant_log[gb], 0);
    chk("t7_done_count", done_log.size() - db, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time=%0t limit=500000", $time);
    $fatal(1, "watchdog");
  end

endmodule
